controle_jogo_rodadas: RTL and testbench

Control unit for the round-based memory game: it sequences the address counter, round counter, play register and timeout of the game datapath. Each round *k* requires the player to repeat memory entries 0..k in order. The block owns the address, round and timeout counters and the key-press edge detector. Memory and comparator stay in the datapath; the comparator returns `igual`. It sits between the top level (`iniciar`, `chaves`) and the datapath (`endereco`, `registra`, `igual`).

---
 rtl/controle_jogo_rodadas.sv | 158 +++++++++++++++
 tb/tb_controle_jogo_rodadas.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_rodadas.sv
// controle_jogo_rodadas
// Control unit for the round-based memory game. It sequences the address,
// round and timeout counters. It also detects key-press edges. The memory and
// the comparator stay in the datapath, which returns `igual`.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low
//   iniciar    start / restart request (only honoured in INICIAL and FIM_*)
//   chaves     player keys, one-hot while pressed, 0 when released
//   igual      datapath: registered play == memoria[endereco]
//   endereco   memory address / play index inside the current round
//   rodada     current round index
//   registra   load-enable for the datapath play register
//   pronto     game over (any outcome)
//   acertou    all rounds completed
//   errou      wrong play
//   timeout    no play within TIMEOUT cycles
//   db_estado  state code, for the debug display
//
// All outputs are registered counters or decodes of the state register, so
// there is no combinational path from any input to any output.

module controle_jogo_rodadas #(
  parameter int RODADAS = 16,   // 1..16
  parameter int TIMEOUT = 5000  // >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  input  logic       igual,
  output logic [3:0] endereco,
  output logic [3:0] rodada,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int              TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TMR_MAX = TW'(TIMEOUT - 1);
  localparam logic [3:0]      ULTIMA  = 4'(RODADAS - 1);

  // These codes are shown on the debug display, so they are fixed values.
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    ESPERA      = 4'd3,
    REGISTRA    = 4'd4,
    COMPARA     = 4'd5,
    PROXIMO     = 4'd6,
    PROX_RODADA = 4'd7,
    FIM_ACERTOU = 4'd10,
    FIM_TIMEOUT = 4'd13,
    FIM_ERROU   = 4'd14
  } estado_t;

  estado_t       estado, estado_nxt;
  logic [3:0]    chaves_q;
  logic [TW-1:0] tmr;
  logic          jogada;

  // A play is the first cycle in which any key is seen after all keys were
  // released. A key that is held down counts once. A key already held when
  // ESPERA is entered does not count.
  assign jogada = (chaves != 4'd0) && (chaves_q == 4'd0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_nxt;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    estado_nxt = estado;
    unique case (estado)
      INICIAL:     if (iniciar) estado_nxt = PREPARA;
      PREPARA:     estado_nxt = ESPERA;
      // A play wins over an expiring timer in the same cycle.
      ESPERA: begin
        if (jogada)              estado_nxt = REGISTRA;
        else if (tmr == TMR_MAX) estado_nxt = FIM_TIMEOUT;
      end
      REGISTRA:    estado_nxt = COMPARA;
      COMPARA: begin
        if (!igual)                  estado_nxt = FIM_ERROU;
        else if (endereco != rodada) estado_nxt = PROXIMO;
        else if (rodada == ULTIMA)   estado_nxt = FIM_ACERTOU;
        else                         estado_nxt = PROX_RODADA;
      end
      PROXIMO:     estado_nxt = ESPERA;
      PROX_RODADA: estado_nxt = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                   if (iniciar) estado_nxt = PREPARA;
      default:     estado_nxt = INICIAL;
    endcase
  end

  // ---------------------------------------------------------------------
  // Key history and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) chaves_q <= 4'd0;
    else        chaves_q <= chaves;
  end

  // endereco and rodada are cleared on the edge that enters PREPARA. This
  // shows a fresh game while in PREPARA. They are cleared again inside
  // PREPARA for completeness. They hold their values in the FIM states so
  // that the display can show where the game ended.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= 4'd0;
      rodada   <= 4'd0;
      tmr      <= '0;
    end else begin
      if (estado_nxt == PREPARA || estado == PREPARA) begin
        endereco <= 4'd0;
        rodada   <= 4'd0;
        tmr      <= '0;
      end else begin
        unique case (estado)
          ESPERA:      tmr <= tmr + 1'b1;
          PROXIMO: begin
            endereco <= endereco + 4'd1;
            tmr      <= '0;
          end
          PROX_RODADA: begin
            rodada   <= rodada + 4'd1;
            endereco <= 4'd0;
            tmr      <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------
  assign registra  = (estado == REGISTRA);
  assign acertou   = (estado == FIM_ACERTOU);
  assign errou     = (estado == FIM_ERROU);
  assign timeout   = (estado == FIM_TIMEOUT);
  assign pronto    = acertou | errou | timeout;
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_jogo_rodadas.sv
module tb_controle_jogo_rodadas;

  localparam int RODADAS = 4;
  localparam int TIMEOUT = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       igual;
  logic [3:0] endereco, rodada, db_estado;
  logic       registra, pronto, acertou, errou, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // End-of-game record: state, address, round, {pronto,acertou,errou,timeout}
  typedef struct packed {
    logic [3:0] est;
    logic [3:0] ende;
    logic [3:0] rod;
    logic [3:0] flg;
  } fim_t;

  fim_t sb_q[$];

  // Model of the datapath: the game memory and the play register.
  logic [3:0] mem [16];
  logic [3:0] play_reg;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
  end

  always @(posedge clock or negedge reset)
    if (!reset)        play_reg <= 4'd0;
    else if (registra) play_reg <= chaves;

  assign igual = (play_reg == mem[endereco]);

  always #5 clock = ~clock;

  controle_jogo_rodadas #(.RODADAS(RODADAS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .igual(igual), .endereco(endereco), .rodada(rodada), .registra(registra),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // iniciar for one cycle; returns just after the edge that enters ESPERA.
  task automatic start_game();
    iniciar = 1'b1; tick();
    iniciar = 1'b0; tick();
  endtask

  // A key pressed from ESPERA. It is held through REGISTRA so that the
  // datapath captures it, then released. The task returns in ESPERA with
  // the key history clear, unless the game has ended.
  task automatic play(input logic [3:0] k);
    chaves = k;    tick(); tick(); tick();
    chaves = 4'd0; tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; chaves = 4'd0;
    tick(); tick();
    n_tests++;
    if ({endereco, rodada, registra, pronto, acertou, errou, timeout, db_estado} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got end=%0d rod=%0d flags=%b est=%0d, want all 0",
               endereco, rodada, {registra, pronto, acertou, errou, timeout}, db_estado);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (db_estado !== 4'd0) begin
      n_fail++; $display("FAIL idle_inicial: got est=%0d, want 0", db_estado);
    end
  endtask

  task automatic test_full_win();
    fim_t e, g;
    sb_q.push_back(fim_t'{4'd10, 4'd3, 4'd3, 4'b1100});
    start_game();
    n_tests++;
    if (db_estado !== 4'd3 || endereco !== 4'd0 || rodada !== 4'd0) begin
      n_fail++; $display("FAIL win_espera: got est=%0d end=%0d rod=%0d, want 3/0/0",
                         db_estado, endereco, rodada);
    end
    for (int r = 0; r < RODADAS; r++) begin
      for (int a = 0; a <= r; a++) play(mem[a]);
      if (r < RODADAS - 1) begin
        n_tests++;
        if (rodada !== 4'(r + 1) || endereco !== 4'd0 || db_estado !== 4'd3) begin
          n_fail++; $display("FAIL win_round%0d: got rod=%0d end=%0d est=%0d, want rod=%0d end=0 est=3",
                             r, rodada, endereco, db_estado, r + 1);
        end
      end
    end
    for (int i = 0; i < 20 && !pronto; i++) tick();
    n_tests++;
    e = sb_q.pop_front();
    g = fim_t'{db_estado, endereco, rodada, {pronto, acertou, errou, timeout}};
    if (g !== e) begin
      n_fail++; $display("FAIL win_end: got %h, want %h", g, e);
    end
  endtask

  task automatic test_error();
    fim_t e, g;
    sb_q.push_back(fim_t'{4'd14, 4'd1, 4'd1, 4'b1010});
    start_game();
    play(4'd1);            // round 0 correct
    play(4'd1);            // round 1, first play correct
    play(4'd4);            // round 1, second play wrong (expects 2)
    for (int i = 0; i < 20 && !pronto; i++) tick();
    n_tests++;
    e = sb_q.pop_front();
    g = fim_t'{db_estado, endereco, rodada, {pronto, acertou, errou, timeout}};
    if (g !== e) begin
      n_fail++; $display("FAIL error_end: got %h, want %h", g, e);
    end
    tick(); tick();
    n_tests++;
    if (errou !== 1'b1 || endereco !== 4'd1 || rodada !== 4'd1) begin
      n_fail++; $display("FAIL error_hold: got errou=%b end=%0d rod=%0d, want 1/1/1",
                         errou, endereco, rodada);
    end
  endtask

  task automatic test_held_key_restart();
    fim_t e, g;
    chaves = 4'd2; tick();          // key held in FIM_ERROU
    iniciar = 1'b1; tick();
    n_tests++;
    if (db_estado !== 4'd1 || errou !== 1'b0) begin
      n_fail++; $display("FAIL restart_prepara: got est=%0d errou=%b, want 1/0", db_estado, errou);
    end
    iniciar = 1'b0; tick();
    n_tests++;
    if (db_estado !== 4'd3 || endereco !== 4'd0 || rodada !== 4'd0) begin
      n_fail++; $display("FAIL restart_clear: got est=%0d end=%0d rod=%0d, want 3/0/0",
                         db_estado, endereco, rodada);
    end
    tick(); tick();
    n_tests++;
    if (db_estado !== 4'd3) begin
      n_fail++; $display("FAIL held_key: got est=%0d, want 3", db_estado);
    end
    iniciar = 1'b1; tick();
    n_tests++;
    if (db_estado !== 4'd3) begin
      n_fail++; $display("FAIL iniciar_in_espera: got est=%0d, want 3", db_estado);
    end
    iniciar = 1'b0;
    chaves = 4'd0; tick();
    chaves = 4'd2; tick();
    n_tests++;
    if (db_estado !== 4'd4 || registra !== 1'b1) begin
      n_fail++; $display("FAIL repress: got est=%0d registra=%b, want 4/1", db_estado, registra);
    end
    sb_q.push_back(fim_t'{4'd14, 4'd0, 4'd0, 4'b1010});   // 2 != mem[0]
    tick(); chaves = 4'd0;
    for (int i = 0; i < 20 && !pronto; i++) tick();
    n_tests++;
    e = sb_q.pop_front();
    g = fim_t'{db_estado, endereco, rodada, {pronto, acertou, errou, timeout}};
    if (g !== e) begin
      n_fail++; $display("FAIL held_end: got %h, want %h", g, e);
    end
  endtask

  task automatic test_timeout();
    fim_t e, g;
    sb_q.push_back(fim_t'{4'd13, 4'd0, 4'd0, 4'b1001});
    start_game();                    // ESPERA entry edge just passed
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    n_tests++;
    if (db_estado !== 4'd3 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got est=%0d timeout=%b, want 3/0", db_estado, timeout);
    end
    tick();
    n_tests++;
    e = sb_q.pop_front();
    g = fim_t'{db_estado, endereco, rodada, {pronto, acertou, errou, timeout}};
    if (g !== e) begin
      n_fail++; $display("FAIL timeout_end: got %h, want %h", g, e);
    end
  endtask

  task automatic test_collision();
    fim_t e, g;
    start_game();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chaves = 4'd4; tick();          // edge seen while the counter is TIMEOUT-1
    n_tests++;
    if (db_estado !== 4'd4 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL collision: got est=%0d timeout=%b, want 4/0", db_estado, timeout);
    end
    sb_q.push_back(fim_t'{4'd14, 4'd0, 4'd0, 4'b1010});   // 4 != mem[0]
    tick(); chaves = 4'd0;
    for (int i = 0; i < 20 && !pronto; i++) tick();
    n_tests++;
    e = sb_q.pop_front();
    g = fim_t'{db_estado, endereco, rodada, {pronto, acertou, errou, timeout}};
    if (g !== e) begin
      n_fail++; $display("FAIL collision_end: got %h, want %h", g, e);
    end
  endtask

  task automatic test_reset_mid();
    start_game();
    play(4'd1);                      // into round 1
    chaves = 4'd1; tick(); tick();   // REGISTRA, then COMPARA
    n_tests++;
    if (db_estado !== 4'd5 || rodada !== 4'd1) begin
      n_fail++; $display("FAIL mid_compara: got est=%0d rod=%0d, want 5/1", db_estado, rodada);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({endereco, rodada, registra, pronto, acertou, errou, timeout, db_estado} !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset: got end=%0d rod=%0d flags=%b est=%0d, want all 0",
               endereco, rodada, {registra, pronto, acertou, errou, timeout}, db_estado);
    end
    chaves = 4'd0;
    tick(); reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (db_estado !== 4'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got est=%0d, want 0", db_estado);
    end
  endtask

  initial begin
    test_reset();
    test_full_win();
    test_error();
    test_held_key_restart();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
